// File: rtl/pe_mac8_engine.sv
// pe_mac8_engine: loads an 8-entry Q8.8 vector, streams 8 weight columns from the buffer and MACs them into 8 saturated dot products; PE_ROUND_EN selects round-half-up, otherwise floor
module pe_mac8_engine #(
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_sel,
  input  logic signed [15:0] x_in,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic signed [15:0] w_1,
  input  logic signed [15:0] w_2,
  input  logic signed [15:0] w_3,
  input  logic signed [15:0] w_4,
  input  logic signed [15:0] w_5,
  input  logic signed [15:0] w_6,
  input  logic signed [15:0] w_7,
  input  logic signed [15:0] w_8,
  output logic               read_en,
  output logic               op_mode,
  output logic               busy,
  output logic signed [15:0] y_1,
  output logic signed [15:0] y_2,
  output logic signed [15:0] y_3,
  output logic signed [15:0] y_4,
  output logic signed [15:0] y_5,
  output logic signed [15:0] y_6,
  output logic signed [15:0] y_7,
  output logic signed [15:0] y_8,
  output logic               out_valid,
  input  logic               out_ready
);
`ifdef PE_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(32768));

  typedef enum logic [2:0] {IDLE, LOAD, MAC, FIN, HOLD} state_t;
  state_t state;
  logic signed [15:0] w [8];
  logic signed [15:0] x [8];
  logic signed [15:0] y [8];
  logic signed [15:0] y_nxt [8];
  logic signed [31:0] prod [8];
  logic signed [ACC_W-1:0] acc [8];
  logic signed [ACC_W-1:0] sh [8];
  logic signed [15:0] xc;
  logic [2:0] k;
  logic [3:0] cnt;
  logic w_vld;

  assign w = '{w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8};
  assign {y_1, y_2, y_3, y_4, y_5, y_6, y_7, y_8} = {y[0], y[1], y[2], y[3], y[4], y[5], y[6], y[7]};
  // buffer output lags read_en by one cycle, so the column seen at cnt pairs with x[cnt-1]
  assign xc = x[3'(cnt - 4'd1)];

  always_comb
    for (int i = 0; i < 8; i++) begin
      prod[i] = w[i] * xc;
      sh[i] = (acc[i] + RND) >>> FRAC;
      y_nxt[i] = sh[i] > Y_MAX ? 16'h7fff : sh[i] < Y_MIN ? 16'h8000 : sh[i][15:0];
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      read_en <= 1'b0;
      x_ready <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      op_mode <= 1'b0;
      w_vld <= 1'b0;
      k <= '0;
      cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        acc[i] <= '0;
        x[i] <= '0;
        y[i] <= '0;
      end
    end else begin
      w_vld <= read_en;
      case (state)
        IDLE: if (start) begin
          op_mode <= op_sel;
          for (int i = 0; i < 8; i++) acc[i] <= '0;
          k <= '0;
          x_ready <= 1'b1;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: if (x_valid && x_ready) begin
          x[k] <= x_in;
          k <= k + 3'd1;
          if (k == 3'd7) begin
            x_ready <= 1'b0;
            read_en <= 1'b1;
            cnt <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (w_vld)
            for (int i = 0; i < 8; i++) acc[i] <= acc[i] + ACC_W'(prod[i]);
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) read_en <= 1'b0;
          if (cnt == 4'd8) state <= FIN;
        end
        FIN: begin
          y <= y_nxt;
          out_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
